// File: rtl/regfile_operand_fetch_pkg.sv
// Shared widths and debug state encoding for the operand-fetch stage.
package regfile_operand_fetch_pkg;

    localparam int unsigned DefElementsW = 5;
    localparam int unsigned DefWidth     = 32;
    localparam int unsigned DefTagW      = 32;

    // Encoded as {out_v, pend_v} so the state falls straight out of the two valid bits.
    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StPend = 2'b01,
        StFull = 2'b10,
        StBoth = 2'b11
    } of_state_e;

    function automatic of_state_e of_state(input logic pend_v, input logic out_v);
        return of_state_e'({out_v, pend_v});
    endfunction

endpackage

// File: rtl/regfile_operand_fetch_if.sv
// Request/response handshake bundle between decode, operand fetch and execute.
interface regfile_operand_fetch_if
    import regfile_operand_fetch_pkg::*;
#(
    parameter int unsigned ELEMENTS_W = DefElementsW,
    parameter int unsigned WIDTH      = DefWidth,
    parameter int unsigned TAG_W      = DefTagW
) ();

    logic                  in_valid;
    logic                  in_ready;
    logic [ELEMENTS_W-1:0] in_rs1_addr;
    logic [ELEMENTS_W-1:0] in_rs2_addr;
    logic [TAG_W-1:0]      in_tag;

    logic                  out_valid;
    logic                  out_ready;
    logic [WIDTH-1:0]      out_rs1_data;
    logic [WIDTH-1:0]      out_rs2_data;
    logic [TAG_W-1:0]      out_tag;

    // Producer of requests and consumer of operands.
    modport master (
        output in_valid, in_rs1_addr, in_rs2_addr, in_tag, out_ready,
        input  in_ready, out_valid, out_rs1_data, out_rs2_data, out_tag
    );

    // The operand-fetch stage itself.
    modport slave (
        input  in_valid, in_rs1_addr, in_rs2_addr, in_tag, out_ready,
        output in_ready, out_valid, out_rs1_data, out_rs2_data, out_tag
    );

endinterface

// File: rtl/regfile_operand_fetch_bypass.sv
// Combinational operand resolution: x0, live write-back, last-cycle write-back, then memory.
module operand_bypass
    import regfile_operand_fetch_pkg::*;
#(
    parameter int unsigned ELEMENTS_W = DefElementsW,
    parameter int unsigned WIDTH      = DefWidth,
    parameter bit          ZERO_REG0  = 1'b1
) (
    input  logic [ELEMENTS_W-1:0] addr_i,
    input  logic                  wb_write_i,
    input  logic [ELEMENTS_W-1:0] wb_addr_i,
    input  logic [WIDTH-1:0]      wb_data_i,
    input  logic                  fwd_v_i,
    input  logic [ELEMENTS_W-1:0] fwd_addr_i,
    input  logic [WIDTH-1:0]      fwd_data_i,
    input  logic [WIDTH-1:0]      rf_data_i,
    output logic [WIDTH-1:0]      data_o
);

    // The memory returns old data on a same-cycle write, so the forward register
    // covers the write that raced the read and the live port covers the current one.
    always_comb begin
        data_o = rf_data_i;
        if (ZERO_REG0 && (addr_i == '0)) begin
            data_o = '0;
        end else if (wb_write_i && (wb_addr_i == addr_i)) begin
            data_o = wb_data_i;
        end else if (fwd_v_i && (fwd_addr_i == addr_i)) begin
            data_o = fwd_data_i;
        end
    end

endmodule

// File: rtl/regfile_operand_fetch.sv
// Operand-fetch stage for a 2R1W register file with write-back bypass and stall replay.
module regfile_operand_fetch
    import regfile_operand_fetch_pkg::*;
#(
    parameter int unsigned ELEMENTS_W = DefElementsW,
    parameter int unsigned WIDTH      = DefWidth,
    parameter int unsigned TAG_W      = DefTagW,
    parameter bit          ZERO_REG0  = 1'b1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,

    regfile_operand_fetch_if.slave stage_if,

    output logic                  rf_read0_o,
    output logic                  rf_read1_o,
    output logic [ELEMENTS_W-1:0] rf_readaddress0_o,
    output logic [ELEMENTS_W-1:0] rf_readaddress1_o,
    input  logic [WIDTH-1:0]      rf_readdata0_i,
    input  logic [WIDTH-1:0]      rf_readdata1_i,

    input  logic                  wb_write_i,
    input  logic [ELEMENTS_W-1:0] wb_writeaddress_i,
    input  logic [WIDTH-1:0]      wb_writedata_i,

    output logic                  rf_write_o,
    output logic [ELEMENTS_W-1:0] rf_writeaddress_o,
    output logic [WIDTH-1:0]      rf_writedata_o
);

    logic                  pend_v_q, pend_v_d;
    logic [ELEMENTS_W-1:0] pend_rs1_q, pend_rs1_d;
    logic [ELEMENTS_W-1:0] pend_rs2_q, pend_rs2_d;
    logic [TAG_W-1:0]      pend_tag_q, pend_tag_d;

    logic                  out_v_q, out_v_d;
    logic [ELEMENTS_W-1:0] out_rs1_addr_q, out_rs1_addr_d;
    logic [ELEMENTS_W-1:0] out_rs2_addr_q, out_rs2_addr_d;
    logic [WIDTH-1:0]      out_rs1_q, out_rs1_d;
    logic [WIDTH-1:0]      out_rs2_q, out_rs2_d;
    logic [TAG_W-1:0]      out_tag_q, out_tag_d;

    logic                  fwd_v_q, fwd_v_d;
    logic [ELEMENTS_W-1:0] fwd_addr_q, fwd_addr_d;
    logic [WIDTH-1:0]      fwd_data_q, fwd_data_d;

    logic                  slot_free;
    logic                  accept;
    logic                  hold_pend;
    logic                  out_load;
    logic                  snoop_rs1;
    logic                  snoop_rs2;
    logic [WIDTH-1:0]      rs1_res;
    logic [WIDTH-1:0]      rs2_res;
    of_state_e             state;

    assign slot_free = !out_v_q || stage_if.out_ready;
    assign hold_pend = pend_v_q && !slot_free;
    assign out_load  = pend_v_q && slot_free;

    assign stage_if.in_ready = !rst_i && (!pend_v_q || slot_free);
    assign accept            = stage_if.in_valid && stage_if.in_ready;

    // A stalled pending request re-reads every cycle so its data never goes stale.
    assign rf_read0_o        = !rst_i && (accept || hold_pend);
    assign rf_read1_o        = !rst_i && (accept || hold_pend);
    assign rf_readaddress0_o = accept ? stage_if.in_rs1_addr : pend_rs1_q;
    assign rf_readaddress1_o = accept ? stage_if.in_rs2_addr : pend_rs2_q;

    assign rf_write_o        = wb_write_i;
    assign rf_writeaddress_o = wb_writeaddress_i;
    assign rf_writedata_o    = wb_writedata_i;

    operand_bypass #(
        .ELEMENTS_W (ELEMENTS_W),
        .WIDTH      (WIDTH),
        .ZERO_REG0  (ZERO_REG0)
    ) u_bypass_rs1 (
        .addr_i     (pend_rs1_q),
        .wb_write_i (wb_write_i),
        .wb_addr_i  (wb_writeaddress_i),
        .wb_data_i  (wb_writedata_i),
        .fwd_v_i    (fwd_v_q),
        .fwd_addr_i (fwd_addr_q),
        .fwd_data_i (fwd_data_q),
        .rf_data_i  (rf_readdata0_i),
        .data_o     (rs1_res)
    );

    operand_bypass #(
        .ELEMENTS_W (ELEMENTS_W),
        .WIDTH      (WIDTH),
        .ZERO_REG0  (ZERO_REG0)
    ) u_bypass_rs2 (
        .addr_i     (pend_rs2_q),
        .wb_write_i (wb_write_i),
        .wb_addr_i  (wb_writeaddress_i),
        .wb_data_i  (wb_writedata_i),
        .fwd_v_i    (fwd_v_q),
        .fwd_addr_i (fwd_addr_q),
        .fwd_data_i (fwd_data_q),
        .rf_data_i  (rf_readdata1_i),
        .data_o     (rs2_res)
    );

    // Held operands track write-back so they are never older than the previous cycle.
    assign snoop_rs1 = wb_write_i && (wb_writeaddress_i == out_rs1_addr_q) &&
                       !(ZERO_REG0 && (out_rs1_addr_q == '0));
    assign snoop_rs2 = wb_write_i && (wb_writeaddress_i == out_rs2_addr_q) &&
                       !(ZERO_REG0 && (out_rs2_addr_q == '0));

    always_comb begin
        pend_v_d   = accept || hold_pend;
        pend_rs1_d = pend_rs1_q;
        pend_rs2_d = pend_rs2_q;
        pend_tag_d = pend_tag_q;
        if (accept) begin
            pend_rs1_d = stage_if.in_rs1_addr;
            pend_rs2_d = stage_if.in_rs2_addr;
            pend_tag_d = stage_if.in_tag;
        end

        out_v_d        = out_load || (out_v_q && !stage_if.out_ready);
        out_rs1_addr_d = out_rs1_addr_q;
        out_rs2_addr_d = out_rs2_addr_q;
        out_rs1_d      = out_rs1_q;
        out_rs2_d      = out_rs2_q;
        out_tag_d      = out_tag_q;
        if (out_load) begin
            out_rs1_addr_d = pend_rs1_q;
            out_rs2_addr_d = pend_rs2_q;
            out_rs1_d      = rs1_res;
            out_rs2_d      = rs2_res;
            out_tag_d      = pend_tag_q;
        end else if (out_v_q) begin
            if (snoop_rs1) out_rs1_d = wb_writedata_i;
            if (snoop_rs2) out_rs2_d = wb_writedata_i;
        end

        fwd_v_d    = wb_write_i;
        fwd_addr_d = wb_writeaddress_i;
        fwd_data_d = wb_writedata_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pend_v_q       <= 1'b0;
            pend_rs1_q     <= '0;
            pend_rs2_q     <= '0;
            pend_tag_q     <= '0;
            out_v_q        <= 1'b0;
            out_rs1_addr_q <= '0;
            out_rs2_addr_q <= '0;
            out_rs1_q      <= '0;
            out_rs2_q      <= '0;
            out_tag_q      <= '0;
            fwd_v_q        <= 1'b0;
            fwd_addr_q     <= '0;
            fwd_data_q     <= '0;
        end else begin
            pend_v_q       <= pend_v_d;
            pend_rs1_q     <= pend_rs1_d;
            pend_rs2_q     <= pend_rs2_d;
            pend_tag_q     <= pend_tag_d;
            out_v_q        <= out_v_d;
            out_rs1_addr_q <= out_rs1_addr_d;
            out_rs2_addr_q <= out_rs2_addr_d;
            out_rs1_q      <= out_rs1_d;
            out_rs2_q      <= out_rs2_d;
            out_tag_q      <= out_tag_d;
            fwd_v_q        <= fwd_v_d;
            fwd_addr_q     <= fwd_addr_d;
            fwd_data_q     <= fwd_data_d;
        end
    end

    assign stage_if.out_valid    = out_v_q;
    assign stage_if.out_rs1_data = out_rs1_q;
    assign stage_if.out_rs2_data = out_rs2_q;
    assign stage_if.out_tag      = out_tag_q;

    assign state = of_state(pend_v_q, out_v_q);

    // A backpressured full pipeline must neither move nor take new work.
    a_both_stall_holds: assert property (@(posedge clk_i) disable iff (rst_i)
        (state == StBoth && !stage_if.out_ready) |=>
        (state == StBoth && $stable(stage_if.out_tag)));

    a_both_stall_blocks: assert property (@(posedge clk_i) disable iff (rst_i)
        (state == StBoth && !stage_if.out_ready) |-> !stage_if.in_ready);

endmodule

// File: tb/tb_regfile_operand_fetch.sv
// Directed bench for regfile_operand_fetch with a behavioural 2R1W memory alongside.
module tb_regfile_operand_fetch;
    import regfile_operand_fetch_pkg::*;

    localparam int unsigned EW = 5;
    localparam int unsigned W  = 32;
    localparam int unsigned TW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rf_read0, rf_read1;
    logic [EW-1:0] rf_ra0, rf_ra1;
    logic [W-1:0]  rf_rd0, rf_rd1;
    logic          wb_write;
    logic [EW-1:0] wb_addr;
    logic [W-1:0]  wb_data;
    logic          rf_write;
    logic [EW-1:0] rf_waddr;
    logic [W-1:0]  rf_wdata;
    logic [W-1:0]  mem [2**EW];

    int tests = 0;
    int fails = 0;

    regfile_operand_fetch_if #(.ELEMENTS_W(EW), .WIDTH(W), .TAG_W(TW)) sif ();

    regfile_operand_fetch #(
        .ELEMENTS_W (EW),
        .WIDTH      (W),
        .TAG_W      (TW),
        .ZERO_REG0  (1'b1)
    ) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .stage_if          (sif),
        .rf_read0_o        (rf_read0),
        .rf_read1_o        (rf_read1),
        .rf_readaddress0_o (rf_ra0),
        .rf_readaddress1_o (rf_ra1),
        .rf_readdata0_i    (rf_rd0),
        .rf_readdata1_i    (rf_rd1),
        .wb_write_i        (wb_write),
        .wb_writeaddress_i (wb_addr),
        .wb_writedata_i    (wb_data),
        .rf_write_o        (rf_write),
        .rf_writeaddress_o (rf_waddr),
        .rf_writedata_o    (rf_wdata)
    );

    always #5 clk = ~clk;

    // Memory: registered read returning pre-write data on a same-cycle write.
    always @(posedge clk) begin
        if (rf_read0) rf_rd0 <= mem[rf_ra0];
        if (rf_read1) rf_rd1 <= mem[rf_ra1];
        if (rf_write) mem[rf_waddr] <= rf_wdata;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic v, input logic [EW-1:0] a1, input logic [EW-1:0] a2,
                       input logic [TW-1:0] tag);
        sif.in_valid    = v;
        sif.in_rs1_addr = a1;
        sif.in_rs2_addr = a2;
        sif.in_tag      = tag;
    endtask

    task automatic wb(input logic we, input logic [EW-1:0] a, input logic [W-1:0] d);
        wb_write = we;
        wb_addr  = a;
        wb_data  = d;
    endtask

    initial begin
        sif.out_ready = 1'b1;
        req(1'b0, '0, '0, '0);
        wb(1'b0, '0, '0);

        // Reset: nothing accepted or read, write-back still passes through.
        cyc();
        req(1'b1, 5'd1, 5'd2, 32'hAA);
        wb(1'b1, 5'd9, 32'h99);
        #2;
        chk("rst_in_ready", 32'(sif.in_ready), 32'd0);
        chk("rst_read0", 32'(rf_read0), 32'd0);
        chk("rst_read1", 32'(rf_read1), 32'd0);
        chk("rst_wr_pass", 32'(rf_write), 32'd1);
        chk("rst_wr_data", rf_wdata, 32'h99);
        cyc();
        rst = 1'b0;
        req(1'b0, '0, '0, '0);
        wb(1'b0, '0, '0);
        #2;
        chk("rst_out_valid", 32'(sif.out_valid), 32'd0);
        chk("rst_out_rs1", sif.out_rs1_data, 32'd0);
        chk("rst_out_rs2", sif.out_rs2_data, 32'd0);
        chk("rst_out_tag", sif.out_tag, 32'd0);
        chk("post_rst_in_ready", 32'(sif.in_ready), 32'd1);

        // Preload x0 = 0x1234, x[n] = n*16 for n = 1..8.
        for (int n = 0; n < 9; n++) begin
            cyc();
            wb(1'b1, n[EW-1:0], (n == 0) ? 32'h1234 : 32'(n * 16));
        end
        cyc();
        wb(1'b0, '0, '0);

        // Back-to-back: request k appears two cycles later.
        for (int k = 0; k < 6; k++) begin
            cyc();
            if (k < 4) req(1'b1, 5'(k + 1), 5'(k + 5), 32'(32'h100 + k));
            else req(1'b0, '0, '0, '0);
            #2;
            if (k < 4) chk("b2b_in_ready", 32'(sif.in_ready), 32'd1);
            if (k >= 2) begin
                chk("b2b_valid", 32'(sif.out_valid), 32'd1);
                chk("b2b_rs1", sif.out_rs1_data, 32'((k - 1) * 16));
                chk("b2b_rs2", sif.out_rs2_data, 32'((k + 3) * 16));
                chk("b2b_tag", sif.out_tag, 32'(32'h100 + k - 2));
            end else begin
                chk("b2b_early_valid", 32'(sif.out_valid), 32'd0);
            end
        end
        cyc();
        #2;
        chk("b2b_drain", 32'(sif.out_valid), 32'd0);

        // x0 reads as zero even though memory entry 0 holds 0x1234.
        cyc();
        req(1'b1, 5'd0, 5'd0, 32'h500);
        #2;
        cyc();
        req(1'b0, '0, '0, '0);
        #2;
        cyc();
        #2;
        chk("x0_valid", 32'(sif.out_valid), 32'd1);
        chk("x0_rs1", sif.out_rs1_data, 32'd0);
        chk("x0_rs2", sif.out_rs2_data, 32'd0);
        chk("x0_tag", sif.out_tag, 32'h500);

        // Write in the accept cycle, then write in the cycle after accept.
        cyc();
        req(1'b1, 5'd5, 5'd6, 32'h200);
        wb(1'b1, 5'd5, 32'hDEAD);
        #2;
        cyc();
        req(1'b0, '0, '0, '0);
        wb(1'b0, '0, '0);
        #2;
        cyc();
        #2;
        chk("fwd_rs1", sif.out_rs1_data, 32'hDEAD);
        chk("fwd_rs2", sif.out_rs2_data, 32'h60);
        chk("fwd_tag", sif.out_tag, 32'h200);
        cyc();
        req(1'b1, 5'd5, 5'd6, 32'h201);
        #2;
        cyc();
        req(1'b0, '0, '0, '0);
        wb(1'b1, 5'd5, 32'hBEEF);
        #2;
        cyc();
        wb(1'b0, '0, '0);
        #2;
        chk("wb_live_rs1", sif.out_rs1_data, 32'hBEEF);
        chk("wb_live_tag", sif.out_tag, 32'h201);

        // Stall with both stages full; x7 written mid-stall.
        cyc();
        sif.out_ready = 1'b0;
        req(1'b1, 5'd1, 5'd2, 32'h300);
        #2;
        cyc();
        req(1'b1, 5'd3, 5'd7, 32'h301);
        #2;
        chk("stall_pre_ready", 32'(sif.in_ready), 32'd1);
        for (int s = 0; s < 5; s++) begin
            cyc();
            req(1'b1, 5'd4, 5'd4, 32'h302);
            wb(s == 2, 5'd7, 32'h77);
            #2;
            chk("stall_in_ready", 32'(sif.in_ready), 32'd0);
            chk("stall_valid", 32'(sif.out_valid), 32'd1);
            chk("stall_tag", sif.out_tag, 32'h300);
            chk("stall_rs1", sif.out_rs1_data, 32'h10);
            chk("stall_replay_en", 32'(rf_read1), 32'd1);
            chk("stall_replay_addr", 32'(rf_ra1), 32'd7);
        end
        cyc();
        wb(1'b0, '0, '0);
        sif.out_ready = 1'b1;
        #2;
        chk("release_in_ready", 32'(sif.in_ready), 32'd1);
        chk("release_tag", sif.out_tag, 32'h300);
        cyc();
        req(1'b0, '0, '0, '0);
        #2;
        chk("replay_tag", sif.out_tag, 32'h301);
        chk("replay_rs1", sif.out_rs1_data, 32'h30);
        chk("replay_rs2", sif.out_rs2_data, 32'h77);
        cyc();
        #2;
        chk("after_stall_tag", sif.out_tag, 32'h302);
        chk("after_stall_rs1", sif.out_rs1_data, 32'h40);
        chk("after_stall_rs2", sif.out_rs2_data, 32'h40);
        cyc();
        #2;
        chk("after_stall_drain", 32'(sif.out_valid), 32'd0);

        // Snoop into a held output; x0 stays zero.
        cyc();
        sif.out_ready = 1'b0;
        req(1'b1, 5'd3, 5'd0, 32'h400);
        #2;
        cyc();
        req(1'b0, '0, '0, '0);
        #2;
        cyc();
        wb(1'b1, 5'd3, 32'hABCD);
        #2;
        chk("snoop_valid", 32'(sif.out_valid), 32'd1);
        chk("snoop_before", sif.out_rs1_data, 32'h30);
        cyc();
        wb(1'b1, 5'd0, 32'hFFFF);
        #2;
        chk("snoop_rs1", sif.out_rs1_data, 32'hABCD);
        cyc();
        wb(1'b0, '0, '0);
        sif.out_ready = 1'b1;
        #2;
        chk("snoop_x0_rs2", sif.out_rs2_data, 32'd0);
        chk("snoop_tag", sif.out_tag, 32'h400);
        cyc();
        #2;
        chk("snoop_drain", 32'(sif.out_valid), 32'd0);

        // Reset while both stages are full.
        cyc();
        sif.out_ready = 1'b0;
        req(1'b1, 5'd1, 5'd2, 32'h600);
        #2;
        cyc();
        req(1'b1, 5'd2, 5'd1, 32'h601);
        #2;
        cyc();
        req(1'b0, '0, '0, '0);
        rst = 1'b1;
        #2;
        chk("mid_rst_in_ready", 32'(sif.in_ready), 32'd0);
        chk("mid_rst_read0", 32'(rf_read0), 32'd0);
        chk("mid_rst_prior_valid", 32'(sif.out_valid), 32'd1);
        cyc();
        rst = 1'b0;
        #2;
        chk("mid_rst_valid", 32'(sif.out_valid), 32'd0);
        chk("mid_rst_rs1", sif.out_rs1_data, 32'd0);
        chk("mid_rst_rs2", sif.out_rs2_data, 32'd0);
        chk("mid_rst_tag", sif.out_tag, 32'd0);
        cyc();
        sif.out_ready = 1'b1;
        req(1'b1, 5'd4, 5'd8, 32'h602);
        #2;
        chk("no_stale_valid", 32'(sif.out_valid), 32'd0);
        chk("new_in_ready", 32'(sif.in_ready), 32'd1);
        cyc();
        req(1'b0, '0, '0, '0);
        #2;
        chk("new_lat1_valid", 32'(sif.out_valid), 32'd0);
        cyc();
        #2;
        chk("new_lat2_valid", 32'(sif.out_valid), 32'd1);
        chk("new_rs1", sif.out_rs1_data, 32'h40);
        chk("new_rs2", sif.out_rs2_data, 32'h80);
        chk("new_tag", sif.out_tag, 32'h602);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/regfile_operand_fetch.md
Name: regfile_operand_fetch

Overview:
- Operand-fetch stage that drives the read ports of the 2-read/1-write register-file memory (mem_2r1w).
- Accepts rs1/rs2 requests with a valid/ready handshake and issues both reads.
- Returns both operands, with write-back bypass, x0 handling and stall-safe replay, to the execute stage.
- Also passes the write-back port through to the memory, so it observes every write.

Parameters:
- ELEMENTS_W, 5, register address width; regfile has 2**ELEMENTS_W entries.
- WIDTH, 32, register data width.
- TAG_W, 32, width of the opaque payload carried alongside each request.
- ZERO_REG0, 1, when 1, address 0 always reads as 0.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid&&in_ready.
- in_rs1_addr  in  ELEMENTS_W  operand 1 address.
- in_rs2_addr  in  ELEMENTS_W  operand 2 address.
- in_tag  in  TAG_W  payload.
- rf_read0/rf_read1  out  1  memory read enables.
- rf_readaddress0/rf_readaddress1  out  ELEMENTS_W  memory read addresses.
- rf_readdata0/rf_readdata1  in  WIDTH  memory data, valid the cycle after the read.
- wb_write  in  1  write-back enable.
- wb_writeaddress  in  ELEMENTS_W  write-back address.
- wb_writedata  in  WIDTH  write-back data.
- rf_write/rf_writeaddress/rf_writedata  out  1/ELEMENTS_W/WIDTH  combinational copy of wb_*.
- out_valid  out  1  operands valid.
- out_ready  in  1  consumer accepts.
- out_rs1_data/out_rs2_data  out  WIDTH  operands.
- out_tag  out  TAG_W  payload.

Behaviour:
- Memory contract: read at cycle t returns data at t+1. A same-cycle write to the read address returns OLD data. Readdata is not relied on in cycles after a cycle with the read enable low.
- State: pend_v (read issued last cycle, with pend_rs1/pend_rs2/pend_tag) and out_v (output register full). States:
  - IDLE(0,0)
  - PEND(1,0)
  - FULL(0,1)
  - BOTH(1,1)
- slot_free = !out_v || out_ready.
- in_ready = !rst && (!pend_v || slot_free).
- accept = in_valid && in_ready.
- Read enables: rf_readN = accept || (pend_v && !slot_free).
- Read addresses: request addresses when accept; otherwise pend addresses (replay). Replay refreshes data every stalled cycle.
- Forward register: fwd_v/fwd_addr/fwd_data capture wb_* every cycle. fwd_v <= wb_write.
- Operand resolution for pending addr A, evaluated in cycle t+1, priority highest first:
  1. ZERO_REG0 && A==0 -> 0
  2. wb_write && wb_writeaddress==A -> wb_writedata
  3. fwd_v && fwd_addr==A -> fwd_data
  4. rf_readdataN
- Capture into output: when pend_v && slot_free, the output register loads the resolved operands and pend_tag; out_v<=1.
- Output snoop:
  - When out_v and the output is not being replaced, a write to matching address (nonzero if ZERO_REG0) updates out_rsN_data at the edge.
  - Outputs therefore reflect all writes up to the previous cycle.
- Next-state rules:
  - pend_v <= accept || (pend_v && !slot_free).
  - out_v <= (pend_v && slot_free) || (out_v && !out_ready).
- Latency: accept at t -> out_valid at t+2. Throughput is 1 per cycle with out_ready held high.
- Reset: in the cycle rst is high, in_ready=0 and rf_read0/1=0. At the edge, pend_v=0, out_v=0, fwd_v=0, out_rs1_data=out_rs2_data=0, out_tag=0. In-flight requests are dropped. rf_write* passes through unconditionally.
- out_* is held stable while out_v && !out_ready, except for snoop updates.

Decomposition:
- Package regfile_operand_fetch_pkg holds:
  - default widths;
  - state encoding enum {IDLE, PEND, FULL, BOTH} for assertions/debug.
- Sub-module operand_bypass is instantiated twice, once per operand. It is a combinational priority mux: zero, wb, fwd, memory.

Test Plan:
- Back-to-back: 4 requests on consecutive cycles, rs1=1..4, regfile x[n]=n*16, out_ready=1 -> out_valid from t+2 for 4 cycles, rs1 data 0x10,0x20,0x30,0x40, tags in order.
- Same-cycle write: accept rs1=5 while wb writes x5=0xDEAD -> out_rs1_data=0xDEAD (old memory value ignored). Write x5 the cycle after accept -> also 0xDEAD.
- Stall replay: out_ready=0 for 5 cycles with BOTH occupied; write x7=0x77 during the stall, pending rs2=7 -> on release, captured rs2=0x77, and in_ready=0 throughout the stall.
- Output snoop: out_v held, out_rs1 addr 3; write x3=0xABCD -> next cycle out_rs1_data=0xABCD. Write x0=0xFFFF with rs2=0 -> out_rs2_data remains 0.
- x0: request rs1=0, rs2=0 after memory entry 0 was loaded with 0x1234 -> both outputs 0.
- Reset mid-operation: assert rst in BOTH state for 1 cycle -> next cycle out_valid=0, data/tag=0, no stale output after release; first new request completes with latency 2.
